// File: rtl/kmeans_kn_pipe.sv
// kmeans_kn_pipe
//   Streams n_points 2-D points out of an external combinational memory and
//   assigns each to the nearest of n_k centroids (squared Euclidean distance,
//   lowest index wins ties). Four-stage pipeline: diff -> square -> sum -> argmin.
//
// Ports
//   clk, rst (async, active-low)
//   start, n_points            : begin a pass over n_points points
//   busy, done                 : pass in progress / one-cycle end-of-pass pulse
//   mem_rd_addr, mem_d0/1      : point memory read port (data valid same cycle)
//   cent_wr, cent_idx, cent_d0/1 : centroid write port (accepted only in IDLE)
//   out_valid, out_d0/1, out_k : assignment result stream
//   acc_sel, acc_sum0/1, acc_cnt : per-cluster accumulators (KMEANS_ACC_EN only)
//
// Optional feature macro: KMEANS_ACC_EN
module kmeans_kn_pipe #(
  parameter int data_width = 16,
  parameter int addr_width = 8,
  parameter int n_k        = 4,
  parameter int k_width    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [addr_width:0]   n_points,
  output logic                  busy,
  output logic                  done,
  output logic [addr_width-1:0] mem_rd_addr,
  input  logic [data_width-1:0] mem_d0,
  input  logic [data_width-1:0] mem_d1,
  input  logic                  cent_wr,
  input  logic [k_width-1:0]    cent_idx,
  input  logic [data_width-1:0] cent_d0,
  input  logic [data_width-1:0] cent_d1,
  output logic                  out_valid,
  output logic [data_width-1:0] out_d0,
  output logic [data_width-1:0] out_d1,
  output logic [k_width-1:0]    out_k
`ifdef KMEANS_ACC_EN
  ,
  input  logic [k_width-1:0]               acc_sel,
  output logic [data_width+addr_width:0]   acc_sum0,
  output logic [data_width+addr_width:0]   acc_sum1,
  output logic [addr_width:0]              acc_cnt
`endif
);

  localparam int unsigned NK     = n_k;
  localparam int          DW     = data_width;
  localparam int          DIFF_W = DW + 1;
  localparam int          SQ_W   = 2 * DW + 2;
  localparam int          DIST_W = 2 * DW + 3;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_nxt;

  logic [addr_width-1:0] addr_q;
  logic [addr_width:0]   n_reg;
  logic                  last_addr;

  logic [DW-1:0] cent0 [NK];
  logic [DW-1:0] cent1 [NK];

  logic                     s0_valid, s1_valid, s2_valid;
  logic [DW-1:0]            s0_d0, s0_d1, s1_d0, s1_d1, s2_d0, s2_d1;
  logic signed [DIFF_W-1:0] s0_diff0 [NK];
  logic signed [DIFF_W-1:0] s0_diff1 [NK];
  logic [SQ_W-1:0]          s1_sq0 [NK];
  logic [SQ_W-1:0]          s1_sq1 [NK];
  logic [DIST_W-1:0]        s2_dist [NK];

  logic [DIST_W-1:0]  best_dist;
  logic [k_width-1:0] best_k;

  // Square of a signed difference: sign-extend to the full product width so the
  // unsigned multiply yields the exact non-negative square in SQ_W bits.
  function automatic logic [SQ_W-1:0] square(input logic signed [DIFF_W-1:0] d);
    logic [SQ_W-1:0] e;
    e = {{(SQ_W - DIFF_W){d[DIFF_W-1]}}, d};
    return e * e;
  endfunction

  assign last_addr   = ({1'b0, addr_q} == (n_reg - (addr_width + 1)'(1)));
  assign mem_rd_addr = addr_q;
  assign busy        = (state == RUN) || (state == DRAIN);
  assign done        = (state == DONE);

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Drain ends when the result leaving stage 3 has nothing valid behind it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (n_points == '0) ? DONE : RUN;
      RUN:     if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (out_valid && !s2_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      n_reg  <= '0;
    end else begin
      if (state == IDLE && start) n_reg <= n_points;
      if (state == RUN && !last_addr) addr_q <= addr_q + addr_width'(1);
      else                            addr_q <= '0;
    end
  end

  // -------------------------------------------------------------- centroids
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < NK; j++) begin
        cent0[j] <= '0;
        cent1[j] <= '0;
      end
    end else if (state == IDLE && cent_wr) begin
      for (int unsigned j = 0; j < NK; j++) begin
        if (cent_idx == k_width'(j)) begin
          cent0[j] <= cent_d0;
          cent1[j] <= cent_d1;
        end
      end
    end
  end

  // --------------------------------------------------------------- pipeline
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s0_d0 <= '0; s0_d1 <= '0;
      s1_d0 <= '0; s1_d1 <= '0;
      s2_d0 <= '0; s2_d1 <= '0;
      for (int unsigned j = 0; j < NK; j++) begin
        s0_diff0[j] <= '0;
        s0_diff1[j] <= '0;
        s1_sq0[j]   <= '0;
        s1_sq1[j]   <= '0;
        s2_dist[j]  <= '0;
      end
    end else begin
      s0_valid <= (state == RUN);
      s1_valid <= s0_valid;
      s2_valid <= s1_valid;
      s0_d0 <= mem_d0;  s0_d1 <= mem_d1;
      s1_d0 <= s0_d0;   s1_d1 <= s0_d1;
      s2_d0 <= s1_d0;   s2_d1 <= s1_d1;
      for (int unsigned j = 0; j < NK; j++) begin
        s0_diff0[j] <= $signed({1'b0, mem_d0}) - $signed({1'b0, cent0[j]});
        s0_diff1[j] <= $signed({1'b0, mem_d1}) - $signed({1'b0, cent1[j]});
        s1_sq0[j]   <= square(s0_diff0[j]);
        s1_sq1[j]   <= square(s0_diff1[j]);
        s2_dist[j]  <= {1'b0, s1_sq0[j]} + {1'b0, s1_sq1[j]};
      end
    end
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    best_dist = s2_dist[0];
    best_k    = '0;
    for (int unsigned j = 1; j < NK; j++) begin
      if (s2_dist[j] < best_dist) begin
        best_dist = s2_dist[j];
        best_k    = k_width'(j);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_d0    <= '0;
      out_d1    <= '0;
      out_k     <= '0;
    end else begin
      out_valid <= s2_valid;
      out_d0    <= s2_d0;
      out_d1    <= s2_d1;
      out_k     <= best_k;
    end
  end

`ifdef KMEANS_ACC_EN
  // ----------------------------------------------------------- accumulators
  localparam int ACC_W = data_width + addr_width + 1;

  logic [ACC_W-1:0]    sum0 [NK];
  logic [ACC_W-1:0]    sum1 [NK];
  logic [addr_width:0] cnt  [NK];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned j = 0; j < NK; j++) begin
        sum0[j] <= '0;
        sum1[j] <= '0;
        cnt[j]  <= '0;
      end
    end else if (state == IDLE && start) begin
      for (int unsigned j = 0; j < NK; j++) begin
        sum0[j] <= '0;
        sum1[j] <= '0;
        cnt[j]  <= '0;
      end
    end else if (out_valid) begin
      for (int unsigned j = 0; j < NK; j++) begin
        if (out_k == k_width'(j)) begin
          sum0[j] <= sum0[j] + ACC_W'(out_d0);
          sum1[j] <= sum1[j] + ACC_W'(out_d1);
          cnt[j]  <= cnt[j] + (addr_width + 1)'(1);
        end
      end
    end
  end

  always_comb begin
    acc_sum0 = '0;
    acc_sum1 = '0;
    acc_cnt  = '0;
    for (int unsigned j = 0; j < NK; j++) begin
      if (acc_sel == k_width'(j)) begin
        acc_sum0 = sum0[j];
        acc_sum1 = sum1[j];
        acc_cnt  = cnt[j];
      end
    end
  end
`endif

endmodule

// File: doc/kmeans_kn_pipe.md
KMEANS_KN_PIPE -- requirements
Module: kmeans_kn_pipe

Interface
REQ-001 Parameter data_width, default 16: unsigned width of each data coordinate and centroid coordinate.
REQ-002 Parameter addr_width, default 8: input-memory address width; up to 2**addr_width points per pass.
REQ-003 Parameter n_k, default 4, legal range 2..8: number of centroids.
REQ-004 Parameter k_width, default 2: cluster-index width; the integrator sets it to ceil(log2(n_k)).
REQ-005 Ports: clk in 1, single clock; all logic is on the rising edge.
REQ-006 Ports: rst in 1, asynchronous, active-low reset.
REQ-007 Ports: start in 1, pulse that begins a pass.
REQ-008 Ports: n_points in addr_width+1, number of points in the pass.
REQ-009 Ports: busy out 1, high during a pass; done out 1, one-cycle pulse at the end of a pass.
REQ-010 Ports: mem_rd_addr out addr_width, read address; mem_d0 in data_width and mem_d1 in data_width, read data, combinational (valid in the same cycle as the address).
REQ-011 Ports: cent_wr in 1, cent_idx in k_width, cent_d0 in data_width and cent_d1 in data_width, centroid write port.
REQ-012 Ports: out_valid out 1, out_d0 out data_width, out_d1 out data_width and out_k out k_width, the assignment result stream.
REQ-013 Ports (only with KMEANS_ACC_EN): acc_sel in k_width; acc_sum0 out data_width+addr_width+1; acc_sum1 out data_width+addr_width+1; acc_cnt out addr_width+1.

Function
REQ-014 FSM states are IDLE, RUN, DRAIN and DONE.
REQ-015 FSM transitions:
- IDLE->RUN on start when n_points>0.
- IDLE->DONE on start when n_points==0.
- RUN->DRAIN after the cycle that issues address n_points-1.
- DRAIN->DONE when the last result leaves the pipeline.
- DONE->IDLE unconditionally after one cycle.
REQ-016 busy is high in RUN and DRAIN; done is high only in DONE.
REQ-017 start is ignored outside IDLE.
REQ-018 In RUN, mem_rd_addr starts at 0 and increments by 1 each cycle.
REQ-019 In RUN, exactly n_points addresses are issued, with no gaps.
REQ-020 In IDLE, mem_rd_addr holds 0.
REQ-021 Centroid registers are written on cent_wr only in IDLE; cent_wr is ignored in RUN, DRAIN and DONE.
REQ-022 A cent_idx value >= n_k is ignored.
REQ-023 Pipeline stage 0: signed differences d - k_j, width data_width+1, for all j in 0..n_k-1 and both dimensions.
REQ-024 Pipeline stage 1: squares, width 2*data_width+2, with no truncation.
REQ-025 Pipeline stage 2: per-centroid distance = sqr0 + sqr1, width 2*data_width+3.
REQ-026 Pipeline stage 3: argmin over the n_k distances; on a tie, the lowest index wins.
REQ-027 out_valid, out_d0, out_d1 and out_k appear exactly 4 cycles after the cycle in which the corresponding address is issued.
REQ-028 out_d0 and out_d1 are the point coordinates, delayed in step with the pipeline.
REQ-029 out_valid is asserted only for issued addresses.
REQ-030 The DRAIN->DONE transition occurs in the cycle after the last out_valid.
REQ-031 done pulses exactly 1 cycle after the final out_valid.
REQ-032 A pass of n_points>0 occupies n_points+5 cycles from the start edge to the done cycle, inclusive.

Reset
REQ-033 While rst is low, all state clears immediately, without waiting for a clock edge.
REQ-034 During reset: FSM=IDLE, mem_rd_addr=0, busy=0, done=0, out_valid=0, out_d0=0, out_d1=0, out_k=0.
REQ-035 During reset: all pipeline registers=0, all centroids=0, and all accumulators and counts=0.
REQ-036 A reset asserted mid-pass abandons the pass; no done pulse is produced for it.

Configuration
REQ-037 Macro KMEANS_ACC_EN: when defined, the block keeps a per-cluster sum of d0, a per-cluster sum of d1, and a per-cluster point count.
REQ-038 With KMEANS_ACC_EN, on each out_valid: sum0[out_k] += out_d0, sum1[out_k] += out_d1 and cnt[out_k] += 1.
REQ-039 With KMEANS_ACC_EN, all accumulators clear on an accepted start.
REQ-040 With KMEANS_ACC_EN, acc_sum0, acc_sum1 and acc_cnt combinationally present the entry at acc_sel; acc_sel >= n_k reads 0.
REQ-041 Without KMEANS_ACC_EN, the acc_* ports and the accumulator logic are absent, and all other behaviour is identical.

Verification
REQ-042 Scenario, basic assignment: n_k=2, centroids (0,0) and (10,10), points (1,2), (9,9), (3,4) -> out_k = 0, 1, 0; first out_valid appears 4 cycles after address 0; done appears 1 cycle after the third out_valid.
REQ-043 Scenario, tie-break: centroids (0,0) and (4,0), point (2,0) -> out_k = 0.
REQ-044 Scenario, signed difference: centroid (100,100), other centroid (0,0), point (99,101) -> out_k selects centroid (100,100), showing no unsigned wrap.
REQ-045 Scenario, n_points=0: start -> done pulses 1 cycle later with no out_valid; start pulses while busy are ignored (the address sequence is unaffected).
REQ-046 Scenario, accumulate (KMEANS_ACC_EN defined): n_k=4 over 256 points -> each cnt equals the number of out_k occurrences for that cluster; the cnt values sum to 256; acc_sum values match a reference model.
REQ-047 Scenario, reset mid-RUN: assert rst at address 50 -> all outputs are immediately 0; no done pulse occurs; a subsequent start runs a clean pass.
